// File: rtl/mcpu_control_fsm_if.sv
// ============================================================================
// Module      : mcpu_control_fsm_if
// Description : Control bundle between the MCPU sequencer and its datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mcpu_control_fsm_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      instr;
  logic             zero;
  logic             pc_we;
  logic             ir_we;
  logic             a_we;
  logic             b_we;
  logic             mem_we;
  logic             reg_we;
  logic             mem_addr_sel;
  logic [1:0]       reg_dst;
  logic [1:0]       reg_in;
  logic             alu_src_a;
  logic [1:0]       alu_src_b;
  logic [2:0]       alu_op;
  logic [1:0]       pc_src;
  logic [3:0]       state;
  logic             retire;
  logic [CNT_W-1:0] retired_count;
  logic             halted;

  // Sequencer side: consumes IR/flag, drives every control line.
  modport master (
    input  instr, zero,
    output pc_we, ir_we, a_we, b_we, mem_we, reg_we, mem_addr_sel,
           reg_dst, reg_in, alu_src_a, alu_src_b, alu_op, pc_src,
           state, retire, retired_count, halted
  );

  // Datapath side.
  modport slave (
    output instr, zero,
    input  pc_we, ir_we, a_we, b_we, mem_we, reg_we, mem_addr_sel,
           reg_dst, reg_in, alu_src_a, alu_src_b, alu_op, pc_src,
           state, retire, retired_count, halted
  );
endinterface

`default_nettype wire

// File: rtl/mcpu_control_fsm.sv
// ============================================================================
// Module      : mcpu_control_fsm
// Description : Multi-cycle MCPU control sequencer with retire counter/halt.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcpu_control_fsm #(
  parameter int CNT_W = 16
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mcpu_control_fsm_if.master bus
);

  localparam logic [3:0] c_FETCH     = 4'd0;
  localparam logic [3:0] c_DECODE    = 4'd1;
  localparam logic [3:0] c_MEM_ADDR  = 4'd2;
  localparam logic [3:0] c_MEM_READ  = 4'd3;
  localparam logic [3:0] c_LW_WB     = 4'd4;
  localparam logic [3:0] c_MEM_WRITE = 4'd5;
  localparam logic [3:0] c_R_EXEC    = 4'd6;
  localparam logic [3:0] c_R_WB      = 4'd7;
  localparam logic [3:0] c_I_EXEC    = 4'd8;
  localparam logic [3:0] c_I_WB      = 4'd9;
  localparam logic [3:0] c_BRANCH    = 4'd10;
  localparam logic [3:0] c_JUMP      = 4'd11;
  localparam logic [3:0] c_JR        = 4'd12;
  localparam logic [3:0] c_HALT      = 4'd13;

  localparam logic [5:0] c_OP_RTYPE  = 6'h00;
  localparam logic [5:0] c_OP_J      = 6'h02;
  localparam logic [5:0] c_OP_JAL    = 6'h03;
  localparam logic [5:0] c_OP_BEQ    = 6'h04;
  localparam logic [5:0] c_OP_BNE    = 6'h05;
  localparam logic [5:0] c_OP_ADDI   = 6'h08;
  localparam logic [5:0] c_OP_XORI   = 6'h0E;
  localparam logic [5:0] c_OP_LW     = 6'h23;
  localparam logic [5:0] c_OP_SW     = 6'h2B;

  localparam logic [5:0] c_FN_ADD    = 6'h20;
  localparam logic [5:0] c_FN_SUB    = 6'h22;
  localparam logic [5:0] c_FN_SLT    = 6'h2A;
  localparam logic [5:0] c_FN_JR     = 6'h08;

  localparam logic [2:0] c_ALU_ADD   = 3'd0;
  localparam logic [2:0] c_ALU_SUB   = 3'd1;
  localparam logic [2:0] c_ALU_XOR   = 3'd2;
  localparam logic [2:0] c_ALU_SLT   = 3'd3;

  localparam logic [CNT_W-1:0] c_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       r_state;
  logic [3:0]       w_next_state;
  logic [CNT_W-1:0] r_retired_count;
  logic [5:0]       w_opcode;
  logic [5:0]       w_funct;
  logic             w_unused_instr;

  logic             w_pc_we;
  logic             w_ir_we;
  logic             w_a_we;
  logic             w_b_we;
  logic             w_mem_we;
  logic             w_reg_we;
  logic             w_mem_addr_sel;
  logic [1:0]       w_reg_dst;
  logic [1:0]       w_reg_in;
  logic             w_alu_src_a;
  logic [1:0]       w_alu_src_b;
  logic [2:0]       w_alu_op;
  logic [1:0]       w_pc_src;
  logic             w_retire;

  assign w_opcode       = bus.instr[31:26];
  assign w_funct        = bus.instr[5:0];
  assign w_unused_instr = ^bus.instr[25:6];

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= c_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode
  always_comb begin
    w_next_state = c_HALT;
    case (r_state)
      c_FETCH: w_next_state = c_DECODE;
      c_DECODE: begin
        case (w_opcode)
          c_OP_LW, c_OP_SW:     w_next_state = c_MEM_ADDR;
          c_OP_RTYPE: begin
            case (w_funct)
              c_FN_ADD, c_FN_SUB, c_FN_SLT: w_next_state = c_R_EXEC;
              c_FN_JR:                      w_next_state = c_JR;
              default:                      w_next_state = c_HALT;
            endcase
          end
          c_OP_ADDI, c_OP_XORI: w_next_state = c_I_EXEC;
          c_OP_BEQ, c_OP_BNE:   w_next_state = c_BRANCH;
          c_OP_J, c_OP_JAL:     w_next_state = c_JUMP;
          default:              w_next_state = c_HALT;
        endcase
      end
      c_MEM_ADDR:  w_next_state = (w_opcode == c_OP_LW) ? c_MEM_READ : c_MEM_WRITE;
      c_MEM_READ:  w_next_state = c_LW_WB;
      c_R_EXEC:    w_next_state = c_R_WB;
      c_I_EXEC:    w_next_state = c_I_WB;
      c_LW_WB, c_MEM_WRITE, c_R_WB, c_I_WB,
      c_BRANCH, c_JUMP, c_JR: w_next_state = c_FETCH;
      c_HALT:      w_next_state = c_HALT;
      default:     w_next_state = c_HALT;
    endcase
  end

  // Output decode
  always_comb begin
    w_pc_we        = 1'b0;
    w_ir_we        = 1'b0;
    w_a_we         = 1'b0;
    w_b_we         = 1'b0;
    w_mem_we       = 1'b0;
    w_reg_we       = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_reg_dst      = 2'd0;
    w_reg_in       = 2'd0;
    w_alu_src_a    = 1'b0;
    w_alu_src_b    = 2'd0;
    w_alu_op       = c_ALU_ADD;
    w_pc_src       = 2'd0;
    w_retire       = 1'b0;
    case (r_state)
      c_FETCH: begin
        w_ir_we     = 1'b1;
        w_alu_src_b = 2'd3;
        w_pc_we     = 1'b1;
      end
      c_DECODE: begin
        w_a_we      = 1'b1;
        w_b_we      = 1'b1;
        w_alu_src_b = 2'd2;
      end
      c_MEM_ADDR: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'd1;
      end
      c_MEM_READ: w_mem_addr_sel = 1'b1;
      c_LW_WB: begin
        w_reg_we  = 1'b1;
        w_reg_dst = 2'd1;
        w_retire  = 1'b1;
      end
      c_MEM_WRITE: begin
        w_mem_we       = 1'b1;
        w_mem_addr_sel = 1'b1;
        w_retire       = 1'b1;
      end
      c_R_EXEC: begin
        w_alu_src_a = 1'b1;
        case (w_funct)
          c_FN_SUB: w_alu_op = c_ALU_SUB;
          c_FN_SLT: w_alu_op = c_ALU_SLT;
          default:  w_alu_op = c_ALU_ADD;
        endcase
      end
      c_R_WB: begin
        w_reg_we = 1'b1;
        w_reg_in = 2'd1;
        w_retire = 1'b1;
      end
      c_I_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = 2'd1;
        w_alu_op    = (w_opcode == c_OP_XORI) ? c_ALU_XOR : c_ALU_ADD;
      end
      c_I_WB: begin
        w_reg_we  = 1'b1;
        w_reg_dst = 2'd1;
        w_reg_in  = 2'd1;
        w_retire  = 1'b1;
      end
      c_BRANCH: begin
        // opcode bit 0 distinguishes BNE from BEQ
        w_alu_src_a = 1'b1;
        w_alu_op    = c_ALU_SUB;
        w_pc_src    = 2'd1;
        w_pc_we     = bus.zero ^ bus.instr[26];
        w_retire    = 1'b1;
      end
      c_JUMP: begin
        w_pc_src = 2'd2;
        w_pc_we  = 1'b1;
        w_retire = 1'b1;
        if (w_opcode == c_OP_JAL) begin
          w_reg_we  = 1'b1;
          w_reg_dst = 2'd2;
          w_reg_in  = 2'd2;
        end
      end
      c_JR: begin
        w_pc_src = 2'd3;
        w_pc_we  = 1'b1;
        w_retire = 1'b1;
      end
      default: ;
    endcase

    // While reset is held, selects keep FETCH values but nothing is written.
    if (!reset) begin
      w_pc_we  = 1'b0;
      w_ir_we  = 1'b0;
      w_a_we   = 1'b0;
      w_b_we   = 1'b0;
      w_mem_we = 1'b0;
      w_reg_we = 1'b0;
      w_retire = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired_count <= '0;
    end else if (w_retire) begin
      r_retired_count <= r_retired_count + c_CNT_ONE;
    end
  end

  assign bus.pc_we         = w_pc_we;
  assign bus.ir_we         = w_ir_we;
  assign bus.a_we          = w_a_we;
  assign bus.b_we          = w_b_we;
  assign bus.mem_we        = w_mem_we;
  assign bus.reg_we        = w_reg_we;
  assign bus.mem_addr_sel  = w_mem_addr_sel;
  assign bus.reg_dst       = w_reg_dst;
  assign bus.reg_in        = w_reg_in;
  assign bus.alu_src_a     = w_alu_src_a;
  assign bus.alu_src_b     = w_alu_src_b;
  assign bus.alu_op        = w_alu_op;
  assign bus.pc_src        = w_pc_src;
  assign bus.state         = r_state;
  assign bus.retire        = w_retire;
  assign bus.retired_count = r_retired_count;
  assign bus.halted        = (r_state == c_HALT);

endmodule

`default_nettype wire
